// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: sequences PC/IR/regfile/ALU/memory, traps on illegal opcodes
// and memory timeouts, counts retired instructions. Strobes are combinational from registered state.
module control_multiciclo #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [6:0]       opcode,
   input  logic             cond_true,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic             pc_src,
   output logic             busy,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] instret
);

   localparam int WW = $clog2(WAIT_MAX + 1);

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             timeout;
   logic             retire;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         fault_q   <= 2'd0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         fault_q   <= fault_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      result_src = 2'd0;
      pc_src     = 1'b0;
      // This cycle would be the WAIT_MAX-th consecutive one without a handshake.
      timeout    = !mem_ready && (wait_q == WW'(WAIT_MAX - 1));

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd2;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_TRAP;
               fault_d = 2'd2;
            end
         end

         S_DECODE: begin
            alu_src_a = 2'd3;
            alu_src_b = 2'd1;
            case (opcode)
               OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
               OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXECUTE;
               default: begin
                  state_d = S_TRAP;
                  fault_d = 2'd1;
               end
            endcase
         end

         S_EXECUTE: begin
            case (opcode)
               OP_R: begin
                  alu_src_a = 2'd1;
                  alu_op    = 2'd2;
                  state_d   = S_WRITEBACK;
               end
               OP_I: begin
                  alu_src_a = 2'd1;
                  alu_src_b = 2'd1;
                  alu_op    = 2'd2;
                  state_d   = S_WRITEBACK;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a = 2'd1;
                  alu_src_b = 2'd1;
                  state_d   = S_MEMORY;
               end
               OP_BRANCH: begin
                  alu_src_a = 2'd1;
                  alu_op    = 2'd1;
                  pc_write  = cond_true;
                  pc_src    = 1'b1;
                  state_d   = S_FETCH;
               end
               OP_JAL: begin
                  pc_write   = 1'b1;
                  pc_src     = 1'b1;
                  reg_write  = 1'b1;
                  result_src = 2'd2;
                  state_d    = S_FETCH;
               end
               OP_JALR: begin
                  alu_src_a = 2'd1;
                  alu_src_b = 2'd1;
                  state_d   = S_WRITEBACK;
               end
               OP_LUI: begin
                  alu_src_a = 2'd2;
                  alu_src_b = 2'd1;
                  state_d   = S_WRITEBACK;
               end
               OP_AUIPC: begin
                  alu_src_a = 2'd3;
                  alu_src_b = 2'd1;
                  state_d   = S_WRITEBACK;
               end
               default: begin
                  // IR is stable after DECODE, so only a corrupted opcode lands here.
                  state_d = S_TRAP;
                  fault_d = 2'd1;
               end
            endcase
         end

         S_MEMORY: begin
            mem_read  = (opcode == OP_LOAD);
            mem_write = (opcode != OP_LOAD);
            if (mem_ready) begin
               state_d = (opcode == OP_LOAD) ? S_WRITEBACK : S_FETCH;
            end else if (timeout) begin
               state_d = S_TRAP;
               fault_d = 2'd2;
            end
         end

         S_WRITEBACK: begin
            reg_write = 1'b1;
            if (opcode == OP_LOAD) begin
               result_src = 2'd1;
            end else if (opcode == OP_JALR) begin
               result_src = 2'd2;
               pc_write   = 1'b1;
               pc_src     = 1'b1;
            end
            state_d = S_FETCH;
         end

         default: state_d = S_TRAP;
      endcase
   end

   always_comb begin
      wait_d = '0;
      if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready) begin
         wait_d = wait_q + WW'(1);
      end else if (state_d == state_q) begin
         wait_d = wait_q;
      end

      retire    = (state_d == S_FETCH) &&
                  (state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK);
      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   assign busy    = (state_q != S_IDLE) && (state_q != S_TRAP);
   assign fault   = fault_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized scoreboard bench for control_multiciclo: an instruction-level phase model pushes
// the expected per-cycle output record; an independent monitor pops and compares each cycle.
module tb_control_multiciclo;

   localparam int WAIT_MAX = 16;
   localparam int CNT_W    = 4;

   typedef struct packed {
      logic [3:0] instret;
      logic [1:0] fault;
      logic       busy;
      logic       pc_src;
      logic [1:0] res;
      logic [1:0] op;
      logic [1:0] b;
      logic [1:0] a;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       ir_write;
      logic       pc_write;
   } obs_t;

   logic             CLK = 1'b0;
   logic             RST_n = 1'b0;
   logic [6:0]       opcode = 7'h00;
   logic             cond_true = 1'b0;
   logic             mem_ready = 1'b0;
   logic             pc_write, ir_write, mem_read, mem_write, reg_write, pc_src, busy;
   logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src, fault;
   logic [CNT_W-1:0] instret;

   control_multiciclo #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .cond_true(cond_true), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .pc_src(pc_src), .busy(busy), .fault(fault), .instret(instret)
   );

   always #5 CLK = ~CLK;

   obs_t act;
   assign act = {instret, fault, busy, pc_src, result_src, alu_op, alu_src_b, alu_src_a,
                 reg_write, mem_write, mem_read, ir_write, pc_write};

   obs_t  exp_q[$];
   obs_t  msk_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cycle  = 0;

   int         model_cnt   = 0;
   logic [1:0] model_fault = 2'd0;

   logic [6:0] legal_ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   // Monitor: one expected record per clock, compared at the falling edge.
   initial begin
      obs_t  e;
      obs_t  m;
      string t;
      forever begin
         @(negedge CLK);
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (((act ^ e) & m) != '0) begin
               errors++;
               $display("FAIL cycle %0d %s: got %h required %h (mask %h)", cycle, t, act, e, m);
            end
         end
      end
   end

   function automatic bit is_legal(input logic [6:0] o);
      bit r = 1'b0;
      foreach (legal_ops[i]) if (legal_ops[i] == o) r = 1'b1;
      return r;
   endfunction

   function automatic obs_t base();
      obs_t e = '0;
      e.busy    = 1'b1;
      e.fault   = model_fault;
      e.instret = model_cnt[3:0];
      return e;
   endfunction

   function automatic obs_t mk_mask(input obs_t e, input bit alu_care, input bit pcs_care);
      obs_t m = '1;
      if (!alu_care) begin
         m.a  = 2'd0;
         m.b  = 2'd0;
         m.op = 2'd0;
      end
      if (!e.reg_write) m.res = 2'd0;
      if (!pcs_care && !e.pc_write) m.pc_src = 1'b0;
      return m;
   endfunction

   // Called at posedge+1: drive inputs for this cycle, queue its expected outputs.
   task automatic step(input obs_t e, input obs_t m, input string t,
                       input logic rdy, input logic cnd, input logic [6:0] opc);
      mem_ready = rdy;
      cond_true = cnd;
      opcode    = opc;
      exp_q.push_back(e);
      msk_q.push_back(m);
      tag_q.push_back(t);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      obs_t z = '0;
      RST_n       = 1'b0;
      model_cnt   = 0;
      model_fault = 2'd0;
      step(z, '1, "reset", 1'($urandom), 1'($urandom), 7'($urandom));
      RST_n = 1'b1;
      step(z, '1, "idle", 1'($urandom), 1'($urandom), 7'($urandom));
   endtask

   task automatic trap_cycles(input int n);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         e         = '0;
         e.fault   = model_fault;
         e.instret = model_cnt[3:0];
         step(e, '1, "trap", 1'($urandom), 1'($urandom), 7'($urandom));
      end
   endtask

   // One memory-port phase: ready arrives after w idle cycles unless the timeout hits first.
   task automatic access(input string t, input bit is_fetch, input bit is_load, input int w,
                         input logic [6:0] opc, output bit ok);
      obs_t e;
      logic rdy;
      ok = 1'b0;
      for (int i = 0; i < WAIT_MAX; i++) begin
         rdy = (i == w);
         e   = base();
         if (is_fetch) begin
            e.mem_read = 1'b1;
            e.b        = 2'd2;
            e.pc_write = rdy;
            e.ir_write = rdy;
         end else begin
            e.mem_read  = is_load;
            e.mem_write = !is_load;
         end
         step(e, mk_mask(e, is_fetch, is_fetch), t, rdy, 1'($urandom),
              is_fetch ? 7'($urandom) : opc);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) model_fault = 2'd2;
   endtask

   task automatic run_instr(input logic [6:0] opc, input logic cnd, input int wf, input int wm);
      obs_t e;
      bit   ok;
      bit   alu;
      access("fetch", 1'b1, 1'b0, wf, opc, ok);
      if (!ok) begin
         trap_cycles(3);
         do_reset();
         return;
      end
      e   = base();
      e.a = 2'd3;
      e.b = 2'd1;
      step(e, mk_mask(e, 1'b1, 1'b0), "decode", 1'($urandom), 1'($urandom), opc);
      if (!is_legal(opc)) begin
         model_fault = 2'd1;
         trap_cycles(3);
         do_reset();
         return;
      end
      e   = base();
      alu = 1'b1;
      case (opc)
         7'h33: begin e.a = 2'd1; e.op = 2'd2; end
         7'h13: begin e.a = 2'd1; e.b = 2'd1; e.op = 2'd2; end
         7'h03, 7'h23, 7'h67: begin e.a = 2'd1; e.b = 2'd1; end
         7'h63: begin e.a = 2'd1; e.op = 2'd1; e.pc_write = cnd; e.pc_src = 1'b1; end
         7'h6F: begin
            alu = 1'b0;
            e.pc_write = 1'b1; e.pc_src = 1'b1; e.reg_write = 1'b1; e.res = 2'd2;
         end
         7'h37: begin e.a = 2'd2; e.b = 2'd1; end
         default: begin e.a = 2'd3; e.b = 2'd1; end
      endcase
      step(e, mk_mask(e, alu, 1'b1), "execute", 1'($urandom), cnd, opc);
      if (opc == 7'h63 || opc == 7'h6F) begin
         model_cnt = (model_cnt + 1) % 16;
         return;
      end
      if (opc == 7'h03 || opc == 7'h23) begin
         access("memory", 1'b0, opc == 7'h03, wm, opc, ok);
         if (!ok) begin
            trap_cycles(3);
            do_reset();
            return;
         end
         if (opc == 7'h23) begin
            model_cnt = (model_cnt + 1) % 16;
            return;
         end
      end
      e           = base();
      e.reg_write = 1'b1;
      e.res       = (opc == 7'h03) ? 2'd1 : (opc == 7'h67) ? 2'd2 : 2'd0;
      if (opc == 7'h67) begin
         e.pc_write = 1'b1;
         e.pc_src   = 1'b1;
      end
      step(e, mk_mask(e, 1'b0, 1'b0), "writeback", 1'($urandom), 1'($urandom), opc);
      model_cnt = (model_cnt + 1) % 16;
   endtask

   initial begin
      obs_t e;
      bit   ok;
      logic [6:0] opc;
      int   wf, wm;

      @(posedge CLK);
      #1;
      do_reset();

      run_instr(7'h13, 1'b0, 0, 0);           // addi
      run_instr(7'h03, 1'b0, 0, 3);           // lw with 3 wait cycles
      run_instr(7'h63, 1'b1, 0, 0);           // beq taken
      run_instr(7'h63, 1'b0, 0, 0);           // beq not taken
      foreach (legal_ops[i]) run_instr(legal_ops[i], 1'($urandom), 0, 0);
      run_instr(7'h23, 1'b0, 2, 5);
      run_instr(7'h13, 1'b0, WAIT_MAX - 1, 0);  // ready on the last allowed cycle
      run_instr(7'h13, 1'b0, WAIT_MAX, 0);      // fetch timeout
      run_instr(7'h13, 1'b0, 0, 0);
      run_instr(7'h03, 1'b0, 0, WAIT_MAX + 4);  // memory timeout
      run_instr(7'h7F, 1'b0, 0, 0);             // illegal opcode
      for (int i = 0; i < 18; i++) run_instr(7'h13, 1'b0, 0, 0);  // counter wrap

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
         else opc = legal_ops[$urandom_range(0, 8)];
         wf = ($urandom_range(0, 19) == 0) ? WAIT_MAX + 1 : int'($urandom_range(0, 3));
         wm = ($urandom_range(0, 19) == 0) ? WAIT_MAX + 1 : int'($urandom_range(0, 4));
         run_instr(opc, 1'($urandom), wf, wm);
      end

      // Reset in the middle of a store's memory phase.
      do_reset();
      run_instr(7'h13, 1'b0, 0, 0);
      run_instr(7'h13, 1'b0, 0, 0);
      access("fetch", 1'b1, 1'b0, 0, 7'h23, ok);
      e   = base();
      e.a = 2'd3;
      e.b = 2'd1;
      step(e, mk_mask(e, 1'b1, 1'b0), "decode", 1'b0, 1'b0, 7'h23);
      e   = base();
      e.a = 2'd1;
      e.b = 2'd1;
      step(e, mk_mask(e, 1'b1, 1'b1), "execute", 1'b0, 1'b0, 7'h23);
      e           = base();
      e.mem_write = 1'b1;
      step(e, mk_mask(e, 1'b0, 1'b0), "memory", 1'b0, 1'b0, 7'h23);
      do_reset();
      run_instr(7'h13, 1'b0, 0, 0);

      @(negedge CLK);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d records left required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
